// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared stage-state encoding for pipeline stage registers
package pipe_stage_reg_pkg;

    // Occupancy encoding; the hazard unit decodes the same values.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - payload register with load and clear-to-bubble
module pipe_data_reg #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over load so a squash always leaves a bubble behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= NOP_VALUE;
        end else if (clear) begin
            q <= NOP_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with skid buffer, stall and flush
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       occupancy
);

    stage_state_e     state;
    stage_state_e     state_next;
    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             main_clear;
    logic             skid_load;
    logic             skid_clear;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    // Handshakes depend only on registered state, enable and reset, never on the far side.
    assign in_ready  = reset & enable & (state != ST_TWO);
    assign out_valid = reset & enable & (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and register load/clear controls; flush discards everything in flight.
    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = data_in;
        if (flush) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next = ST_ONE;
                        main_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_next = ST_TWO;
                        skid_load  = 1'b1;
                    end else if (!in_fire && out_fire) begin
                        state_next = ST_EMPTY;
                        main_clear = 1'b1;
                    end else if (in_fire && out_fire) begin
                        main_load  = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_next = ST_ONE;
                        main_d     = skid_q;
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP_VALUE)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (data_out)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (data_in),
        .q     (skid_q)
    );

endmodule
